hazard_stall_ctrl: RTL

//  Stall/bubble controller for the F/D pipeline register and the PC.

---
 rtl/hazard_stall_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble control for PC, F/D and D/E from register hazards and the mult/div unit.
// Latency: stall, flush and md_start are combinational; md_busy is registered.
// Backpressure: any hazard holds F and D and injects a bubble into E until it clears.
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] rs_tuse_D,
    input  logic [1:0] rt_tuse_D,
    input  logic [4:0] wa_E,
    input  logic [1:0] tnew_E,
    input  logic [4:0] wa_M,
    input  logic [1:0] tnew_M,
    input  logic       md_op_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic       STALL_F,
    output logic       STALL_D,
    output logic       FLUSH_E,
    output logic       md_start,
    output logic       md_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            stall_rs, stall_rt, stall_md, stall;

    // r0 is never a real dependency, so wa==0 cannot raise a match.
    assign stall_rs = (rs_D != 5'd0) &&
                      (((rs_D == wa_E) && (tnew_E > rs_tuse_D)) ||
                       ((rs_D == wa_M) && (tnew_M > rs_tuse_D)));
    assign stall_rt = (rt_D != 5'd0) &&
                      (((rt_D == wa_E) && (tnew_E > rt_tuse_D)) ||
                       ((rt_D == wa_M) && (tnew_M > rt_tuse_D)));

    assign md_busy  = (state != IDLE);
    assign stall_md = md_busy && (md_op_D || md_use_D);

    // Outputs are forced low for the whole time reset is held.
    assign stall    = reset && (stall_rs || stall_rt || stall_md);
    assign STALL_F  = stall;
    assign STALL_D  = stall;
    assign FLUSH_E  = stall;
    assign md_start = reset && md_op_D && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_nxt = md_div_D ? DIV : MULT;
                    cnt_nxt   = md_div_D ? CW'(DIV_LAT) : CW'(MULT_LAT);
                end
            end
            MULT, DIV: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
